// File: rtl/uart_loop_ctl.sv
// UART loopback controller: receives frames on rx, queues good bytes in a small FIFO
// and echoes them on tx unless hold mode is selected; sticky error flags report bad frames.
module uart_loop_ctl #(
    parameter int BAUD_DIV   = 868,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       sw,
    output logic       tx,
    output logic [7:0] led,
    output logic       perr,
    output logic       ferr,
    output logic       ovf
);

    localparam int CNT_W   = $clog2(BAUD_DIV);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = PTR_W + 1;
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [2:0]       DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(FIFO_DEPTH);
    localparam logic             PAR_EN    = (PARITY != 0);
    localparam logic             PAR_ODD   = (PARITY == 2);

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;

    logic rx_meta_q, rx_sync_q, rx_prev_q;
    logic sw_meta_q, sw_sync_q;

    rx_state_t            rx_state_q, rx_state_d;
    logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
    logic [2:0]           rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_par_q, rx_par_d;
    logic                 rx_stop_q, rx_stop_d;
    logic                 rx_done_q, rx_done_d;

    tx_state_t            tx_state_q, tx_state_d;
    logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
    logic [2:0]           tx_bit_q, tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 tx_par_q, tx_par_d;
    logic                 tx_q, tx_d;

    logic [DATA_BITS-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_q, occ_d;

    logic [7:0] led_q, led_d;
    logic       perr_q, perr_d, ferr_q, ferr_d, ovf_q, ovf_d;

    logic bad_par, frame_good, fifo_full, fifo_empty, push_ok, pop;

    // rx idles high, so its synchronizer resets high: only a fresh falling edge starts a frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
            sw_meta_q <= 1'b0;
            sw_sync_q <= 1'b0;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
            sw_meta_q <= sw;
            sw_sync_q <= sw_meta_q;
        end
    end

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_par_d   = rx_par_q;
        rx_stop_d  = rx_stop_q;
        rx_done_d  = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    rx_state_d = RX_START;
                    rx_cnt_d   = '0;
                end
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == DATA_LAST) begin
                        rx_state_d = PAR_EN ? RX_PAR : RX_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_PAR: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_par_d   = rx_sync_q;
                    rx_state_d = RX_STOP;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_stop_d  = rx_sync_q;
                    rx_done_d  = 1'b1;
                    rx_state_d = RX_IDLE;
                end else begin
                    rx_cnt_d = rx_cnt_q + 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    // Frame verdict is taken the clock after the stop sample, while rx_shift_q still holds the byte
    always_comb begin
        bad_par    = PAR_EN && (rx_par_q != ((^rx_shift_q) ^ PAR_ODD));
        frame_good = rx_done_q && rx_stop_q && !bad_par;
        fifo_full  = (occ_q == OCC_FULL);
        fifo_empty = (occ_q == '0);
        push_ok    = frame_good && (!fifo_full || pop);
        wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        occ_d      = occ_q;
        if (push_ok && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (!push_ok && pop) begin
            occ_d = occ_q - 1'b1;
        end
        ferr_d = ferr_q | (rx_done_q && !rx_stop_q);
        perr_d = perr_q | (rx_done_q && rx_stop_q && bad_par);
        ovf_d  = ovf_q | (frame_good && fifo_full && !pop);
        led_d  = led_q;
        if (frame_good) begin
            led_d                = '0;
            led_d[DATA_BITS-1:0] = rx_shift_q;
        end
    end

    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_cnt_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        tx_par_d   = tx_par_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (tx_state_q)
            TX_IDLE: begin
                tx_d = 1'b1;
                if (!sw_sync_q && !fifo_empty) begin
                    pop        = 1'b1;
                    tx_shift_d = fifo_mem[rd_ptr_q];
                    tx_par_d   = (^fifo_mem[rd_ptr_q]) ^ PAR_ODD;
                    tx_d       = 1'b0;
                    tx_cnt_d   = '0;
                    tx_state_d = TX_START;
                end
            end
            TX_START: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_d       = tx_shift_q[0];
                    tx_state_d = TX_DATA;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit_q == DATA_LAST) begin
                        tx_d       = PAR_EN ? tx_par_q : 1'b1;
                        tx_state_d = PAR_EN ? TX_PAR : TX_STOP;
                    end else begin
                        tx_bit_d   = tx_bit_q + 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        tx_d       = tx_shift_q[1];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_PAR: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_d       = 1'b1;
                    tx_state_d = TX_STOP;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == BIT_LAST) begin
                    tx_cnt_d   = '0;
                    tx_d       = 1'b1;
                    tx_state_d = TX_IDLE;
                end else begin
                    tx_cnt_d = tx_cnt_q + 1'b1;
                end
            end
            default: begin
                tx_d       = 1'b1;
                tx_state_d = TX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_par_q   <= 1'b0;
            rx_stop_q  <= 1'b0;
            rx_done_q  <= 1'b0;
            tx_state_q <= TX_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_q       <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            led_q      <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_par_q   <= rx_par_d;
            rx_stop_q  <= rx_stop_d;
            rx_done_q  <= rx_done_d;
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            tx_par_q   <= tx_par_d;
            tx_q       <= tx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            led_q      <= led_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
            ovf_q      <= ovf_d;
        end
    end

    // Storage needs no reset; the occupancy count alone defines which entries are valid
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_mem[wr_ptr_q] <= rx_shift_q;
        end
    end

    assign tx   = tx_q;
    assign led  = led_q;
    assign perr = perr_q;
    assign ferr = ferr_q;
    assign ovf  = ovf_q;

endmodule

// File: doc/uart_loop_ctl.md
UART_LOOP_CTL -- requirements
Module: uart_loop_ctl

Interface
REQ-001 SHALL have parameter BAUD_DIV, default 868: clocks per UART bit, legal range >= 4.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame, legal range 5..8.
REQ-003 SHALL have parameter PARITY, default 0: 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter FIFO_DEPTH, default 16: RX FIFO entries, power of 2, >= 2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port rx, input, 1 bit: UART serial in, idle high, asynchronous to clk.
REQ-008 SHALL have port sw, input, 1 bit: mode, 0 = echo, 1 = hold; asynchronous to clk.
REQ-009 SHALL have port tx, output, 1 bit: UART serial out, idle high.
REQ-010 SHALL have port led, output, 8 bits: last accepted RX byte, zero-extended to 8 bits.
REQ-011 SHALL have port perr, output, 1 bit: sticky parity-error flag.
REQ-012 SHALL have port ferr, output, 1 bit: sticky framing-error flag.
REQ-013 SHALL have port ovf, output, 1 bit: sticky RX FIFO overflow flag.

Function
REQ-014 rx and sw SHALL each pass through a 2-flop synchronizer before use.
REQ-015 RX FSM SHALL use states RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP.
REQ-016 In RX_IDLE, a synchronized rx high-to-low edge SHALL move to RX_START.
REQ-017 In RX_START, rx SHALL be resampled BAUD_DIV/2 clocks after the edge: low -> RX_DATA, high -> RX_IDLE (glitch, nothing recorded).
REQ-018 RX_DATA SHALL take DATA_BITS samples, LSB first, one every BAUD_DIV clocks from the mid-start point; then RX_PAR if PARITY != 0, else RX_STOP.
REQ-019 RX_PAR SHALL sample the parity bit at the next mid-bit point; mismatch with even/odd parity over the data bits marks the frame bad-parity.
REQ-020 RX_STOP SHALL sample the stop bit at the next mid-bit point, then return to RX_IDLE.
REQ-021 Stop bit low SHALL set ferr and discard the byte; a bad-parity frame with a good stop bit SHALL set perr and discard the byte.
REQ-022 A good frame SHALL be pushed into the FIFO, and led updated, on the clock after the stop sample.
REQ-023 Push into a full FIFO SHALL drop the byte and set ovf; led is still updated.
REQ-024 TX FSM SHALL use states TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP; every bit lasts exactly BAUD_DIV clocks.
REQ-025 In TX_IDLE with synchronized sw = 0 and FIFO non-empty, TX SHALL pop one entry and drive the start bit (tx = 0) on the next clock.
REQ-026 TX SHALL send DATA_BITS bits LSB first, then the parity bit if PARITY != 0, then one stop bit (tx = 1), then spend exactly 1 clock in TX_IDLE before the next pop.
REQ-027 A simultaneous push and pop on a full FIFO SHALL accept both and SHALL NOT set ovf.
REQ-028 A push into an empty FIFO SHALL NOT be poppable in the same cycle.
REQ-029 A change of sw mid-frame SHALL NOT abort the frame in progress; hold mode only blocks new pops.
REQ-030 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy 0..FIFO_DEPTH is held in log2(FIFO_DEPTH)+1 bits.
REQ-031 perr, ferr and ovf SHALL clear only on reset.

Reset
REQ-032 While rst = 0, the block SHALL immediately force tx = 1, led = 0, perr = ferr = ovf = 0, both FSMs to IDLE, the FIFO to empty, and all counters to 0; this applies mid-frame too.
REQ-033 The first frame after rst deasserts SHALL be recognised only from a fresh high-to-low rx edge.

Verification (BAUD_DIV = 16, DATA_BITS = 8, FIFO_DEPTH = 4; PARITY = 0 unless stated)
REQ-034 Reset: assert rst = 0 mid-TX-frame -> tx = 1, led = 0x00 and flags = 0 within the same cycle, with no clock edge needed.
REQ-035 Echo: sw = 0, send 0xA5 on rx -> led = 0xA5 one clock after the stop sample; tx emits 0,1,0,1,0,0,1,0,1,1, 16 clocks per bit.
REQ-036 Hold/overflow: sw = 1, send 0x01..0x05 -> ovf = 1, led = 0x05, tx stays 1; then sw = 0 -> tx sends 0x01, 0x02, 0x03, 0x04 with exactly 1 idle clock between frames.
REQ-037 Framing: send 0x3C with the stop bit low -> ferr = 1, led unchanged, no tx frame.
REQ-038 Parity: with PARITY = 1, send 0x07 with parity bit 0 -> perr = 1, byte discarded; resend with parity bit 1 -> led = 0x07 and the byte is echoed.
REQ-039 Glitch: drive rx low for 4 clocks, then high -> no flag set, led unchanged, RX back in RX_IDLE.
